cga_vram_arbiter: RTL and testbench

//  Shares the single 8-bit VRAM between the CGA display fetch path (sequencer/CRTC) and
//  CPU memory cycles in the B8000h window. Display fetches always win; CPU accesses take

---
 rtl/cga_vram_arbiter_pkg.sv | 16 +
 rtl/cga_vram_arbiter_if.sv | 23 ++
 rtl/cga_vram_arbiter_bus_sync.sv | 27 ++
 rtl/cga_vram_arbiter.sv | 135 +++++++++++++
 tb/tb_cga_vram_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/cga_vram_arbiter_pkg.sv
// Shared types and constants for the CGA VRAM arbiter slice.
package cga_vram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACCESS,
        ST_DONE
    } arb_state_t;

    localparam int          ISA_AW        = 20;
    localparam int          ISA_DW        = 8;
    localparam logic [19:0] FB_ADDR_DEF   = 20'hB8000;
    localparam logic [3:0]  VRAM_PAGE_DEF = 4'b0001;

endpackage

// File: rtl/cga_vram_arbiter_if.sv
// ISA memory-cycle signals seen by the VRAM arbiter.
interface cga_vram_arbiter_if;
    import cga_vram_arbiter_pkg::*;

    logic [ISA_AW-1:0] bus_a;
    logic              bus_memr_l;
    logic              bus_memw_l;
    logic [ISA_DW-1:0] bus_d;
    logic [ISA_DW-1:0] bus_out_mem;
    logic              bus_mem_dir;
    logic              bus_rdy;

    modport master (
        output bus_a, bus_memr_l, bus_memw_l, bus_d,
        input  bus_out_mem, bus_mem_dir, bus_rdy
    );

    modport slave (
        input  bus_a, bus_memr_l, bus_memw_l, bus_d,
        output bus_out_mem, bus_mem_dir, bus_rdy
    );

endinterface

// File: rtl/cga_vram_arbiter_bus_sync.sv
// Two-flop synchronizer for asynchronous ISA strobes; resets to RST_VAL.
module cga_vram_arbiter_bus_sync #(
    parameter int         W       = 2,
    parameter logic [W-1:0] RST_VAL = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_sync
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/cga_vram_arbiter.sv
// Arbitrates the 8-bit CGA VRAM between display fetches and CPU cycles in the B8000h window.
module cga_vram_arbiter
    import cga_vram_arbiter_pkg::*;
#(
    parameter logic [19:0] FB_ADDR      = FB_ADDR_DEF,
    parameter bit          USE_BUS_WAIT = 1'b1,
    parameter int          RD_LAT       = 2,
    parameter logic [3:0]  VRAM_PAGE    = VRAM_PAGE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    cga_vram_arbiter_if.slave    isa,
    input  logic [14:0]          disp_a,
    input  logic                 disp_read,
    input  logic                 isa_op_enable,
    output logic [18:0]          ram_a,
    input  logic [7:0]           ram_d,
    output logic [7:0]           ram_dout,
    output logic                 ram_we_l,
    output logic                 cpu_access
);

    arb_state_t  r_state;
    arb_state_t  w_next;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nxt;
    logic        r_we_l;
    logic        w_we_l_nxt;
    logic        w_capture;
    logic        r_is_rd;
    logic [14:0] r_addr;
    logic [7:0]  r_data;
    logic [7:0]  r_out;

    logic [1:0]  w_strb_sync;
    logic        w_rd_s;
    logic        w_wr_s;
    logic        w_win;
    logic        w_memsel;
    logic        w_raw_sel;
    logic        w_strb_held;
    logic        w_last;
    logic        w_cpu_drive;

    cga_vram_arbiter_bus_sync #(.W(2), .RST_VAL(2'b11)) u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async ({isa.bus_memr_l, isa.bus_memw_l}),
        .o_sync  (w_strb_sync)
    );

    assign w_rd_s      = ~w_strb_sync[1];
    assign w_wr_s      = ~w_strb_sync[0];
    assign w_win       = (isa.bus_a[19:15] == FB_ADDR[19:15]);
    assign w_memsel    = w_win & (w_rd_s | w_wr_s);
    assign w_raw_sel   = w_win & (~isa.bus_memr_l | ~isa.bus_memw_l);
    assign w_strb_held = r_is_rd ? w_rd_s : w_wr_s;
    assign w_last      = (r_cnt == 2'(RD_LAT - 1));

    always_comb begin
        w_next     = r_state;
        w_cnt_nxt  = r_cnt;
        w_we_l_nxt = 1'b1;
        w_capture  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_memsel) w_next = ST_REQ;
            end
            ST_REQ: begin
                if (!w_strb_held) begin
                    w_next = ST_IDLE;
                end else if (isa_op_enable && !disp_read) begin
                    w_next     = ST_ACCESS;
                    w_cnt_nxt  = 2'd0;
                    w_we_l_nxt = r_is_rd;
                end
            end
            ST_ACCESS: begin
                // A display fetch that steals the cycle masks the write and retries it next cycle.
                if (!r_is_rd) begin
                    if (disp_read) w_we_l_nxt = 1'b0;
                    else           w_next     = ST_DONE;
                end else if (disp_read) begin
                    w_cnt_nxt = 2'd0;
                end else if (w_last) begin
                    w_capture = 1'b1;
                    w_next    = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            ST_DONE: begin
                if (!w_strb_held) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_we_l  <= 1'b1;
            r_is_rd <= 1'b0;
            r_data  <= 8'h00;
            r_out   <= 8'h00;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            r_we_l  <= w_we_l_nxt;
            if (w_capture) r_out <= ram_d;
            if (r_state == ST_IDLE && w_memsel) begin
                r_is_rd <= w_rd_s;
                if (!w_rd_s) r_data <= isa.bus_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && w_memsel) r_addr <= isa.bus_a[14:0];
    end

    assign w_cpu_drive     = (r_state == ST_ACCESS) && !disp_read;
    assign ram_a           = w_cpu_drive ? {VRAM_PAGE, r_addr} : {VRAM_PAGE, disp_a};
    assign cpu_access      = w_cpu_drive;
    assign ram_we_l        = r_we_l | disp_read;
    assign ram_dout        = r_data;
    assign isa.bus_out_mem = r_out;
    assign isa.bus_mem_dir = w_win & ~isa.bus_memr_l;
    // Raw decode only counts in IDLE so the first wait state lands before the synchronizer catches up.
    assign isa.bus_rdy     = reset | ~(USE_BUS_WAIT &
                             ((r_state == ST_IDLE && w_raw_sel) ||
                              r_state == ST_REQ || r_state == ST_ACCESS));

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed table-driven bench for cga_vram_arbiter plus reset and no-wait corner sequences.
module tb_cga_vram_arbiter;
    import cga_vram_arbiter_pkg::*;

    localparam logic [14:0] DISP = 15'h1234;
    localparam logic [18:0] DA   = 19'h09234;

    logic clk = 1'b0;
    logic reset;
    logic [14:0] disp_a;
    logic disp_read, isa_op_enable;
    logic [7:0] ram_d;
    logic [18:0] ram_a_a, ram_a_b;
    logic [7:0] ram_dout_a, ram_dout_b;
    logic we_a, we_b, cpu_a, cpu_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cga_vram_arbiter_if if_a ();
    cga_vram_arbiter_if if_b ();

    cga_vram_arbiter u_dut (
        .clk(clk), .reset(reset), .isa(if_a),
        .disp_a(disp_a), .disp_read(disp_read), .isa_op_enable(isa_op_enable),
        .ram_a(ram_a_a), .ram_d(ram_d), .ram_dout(ram_dout_a),
        .ram_we_l(we_a), .cpu_access(cpu_a)
    );

    cga_vram_arbiter #(.USE_BUS_WAIT(1'b0), .RD_LAT(1)) u_nw (
        .clk(clk), .reset(reset), .isa(if_b),
        .disp_a(disp_a), .disp_read(disp_read), .isa_op_enable(isa_op_enable),
        .ram_a(ram_a_b), .ram_d(ram_d), .ram_dout(ram_dout_b),
        .ram_we_l(we_b), .cpu_access(cpu_b)
    );

    typedef struct {
        logic        rst, memr_l, memw_l;
        logic [19:0] a;
        logic [7:0]  d;
        logic        dr, op;
        logic [7:0]  rd;
        logic [18:0] e_ram_a;
        logic        e_we_l, e_rdy, e_cpu, e_dir;
        logic [7:0]  e_out, e_dout;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic rst, memr_l, memw_l, input logic [19:0] a,
                        input logic [7:0] d, input logic dr, op, input logic [7:0] rd,
                        input logic [18:0] era, input logic ewe, erdy, ecpu, edir,
                        input logic [7:0] eout, edout);
        vec_t v;
        v.rst = rst; v.memr_l = memr_l; v.memw_l = memw_l; v.a = a; v.d = d;
        v.dr = dr; v.op = op; v.rd = rd; v.e_ram_a = era; v.e_we_l = ewe;
        v.e_rdy = erdy; v.e_cpu = ecpu; v.e_dir = edir; v.e_out = eout; v.e_dout = edout;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; disp_a = DISP; disp_read = 1'b0; isa_op_enable = 1'b0; ram_d = 8'h00;
        if_a.bus_a = '0; if_a.bus_d = '0; if_a.bus_memr_l = 1'b1; if_a.bus_memw_l = 1'b1;
        if_b.bus_a = '0; if_b.bus_d = '0; if_b.bus_memr_l = 1'b1; if_b.bus_memw_l = 1'b1;

        //    rst r w addr      data  dr op rd    | ram_a    we rdy cpu dir out    dout
        addv(1, 1, 1, 20'h0,     8'h00, 0, 0, 8'h00, DA,       1, 1, 0, 0, 8'h00, 8'h00);
        addv(0, 1, 1, 20'h0,     8'h00, 0, 0, 8'h00, DA,       1, 1, 0, 0, 8'h00, 8'h00);
        // CPU write B8123h = 5Ah
        addv(0, 1, 0, 20'hB8123, 8'h5A, 0, 0, 8'h00, DA,       1, 0, 0, 0, 8'h00, 8'h00);
        addv(0, 1, 0, 20'hB8123, 8'h5A, 0, 0, 8'h00, DA,       1, 0, 0, 0, 8'h00, 8'h00);
        addv(0, 1, 0, 20'hB8123, 8'h5A, 0, 0, 8'h00, DA,       1, 0, 0, 0, 8'h00, 8'h5A);
        addv(0, 1, 0, 20'hB8123, 8'h5A, 0, 1, 8'h00, 19'h08123, 0, 0, 1, 0, 8'h00, 8'h5A);
        addv(0, 1, 0, 20'hB8123, 8'h5A, 0, 0, 8'h00, DA,       1, 1, 0, 0, 8'h00, 8'h5A);
        for (int i = 0; i < 3; i++)
            addv(0, 1, 1, 20'h0, 8'h00, 0, 0, 8'h00, DA,       1, 1, 0, 0, 8'h00, 8'h5A);
        // CPU read BC010h, display takes the first offered slot
        for (int i = 0; i < 3; i++)
            addv(0, 0, 1, 20'hBC010, 8'h00, 0, 0, 8'h00, DA,   1, 0, 0, 1, 8'h00, 8'h5A);
        addv(0, 0, 1, 20'hBC010, 8'h00, 1, 1, 8'h00, DA,       1, 0, 0, 1, 8'h00, 8'h5A);
        addv(0, 0, 1, 20'hBC010, 8'h00, 1, 0, 8'h00, DA,       1, 0, 0, 1, 8'h00, 8'h5A);
        addv(0, 0, 1, 20'hBC010, 8'h00, 0, 1, 8'h3C, 19'h0C010, 1, 0, 1, 1, 8'h00, 8'h5A);
        addv(0, 0, 1, 20'hBC010, 8'h00, 0, 0, 8'h3C, 19'h0C010, 1, 0, 1, 1, 8'h00, 8'h5A);
        addv(0, 0, 1, 20'hBC010, 8'h00, 0, 0, 8'h3C, DA,       1, 1, 0, 1, 8'h3C, 8'h5A);
        for (int i = 0; i < 3; i++)
            addv(0, 1, 1, 20'h0, 8'h00, 0, 0, 8'h00, DA,       1, 1, 0, 0, 8'h3C, 8'h5A);
        // write released while waiting in REQ: aborted, slot ignored
        for (int i = 0; i < 3; i++)
            addv(0, 1, 0, 20'hB8200, 8'hA5, 0, 0, 8'h00, DA,   1, 0, 0, 0, 8'h3C, (i == 2) ? 8'hA5 : 8'h5A);
        addv(0, 1, 1, 20'h0,     8'h00, 0, 0, 8'h00, DA,       1, 0, 0, 0, 8'h3C, 8'hA5);
        addv(0, 1, 1, 20'h0,     8'h00, 0, 0, 8'h00, DA,       1, 0, 0, 0, 8'h3C, 8'hA5);
        addv(0, 1, 1, 20'h0,     8'h00, 0, 1, 8'h00, DA,       1, 1, 0, 0, 8'h3C, 8'hA5);
        addv(0, 1, 1, 20'h0,     8'h00, 0, 1, 8'h00, DA,       1, 1, 0, 0, 8'h3C, 8'hA5);
        // read with an illegal display fetch mid-access restarting the latency count
        for (int i = 0; i < 3; i++)
            addv(0, 0, 1, 20'hBC010, 8'h00, 0, 0, 8'h00, DA,   1, 0, 0, 1, 8'h3C, 8'hA5);
        addv(0, 0, 1, 20'hBC010, 8'h00, 0, 1, 8'h77, 19'h0C010, 1, 0, 1, 1, 8'h3C, 8'hA5);
        addv(0, 0, 1, 20'hBC010, 8'h00, 0, 0, 8'h77, 19'h0C010, 1, 0, 1, 1, 8'h3C, 8'hA5);
        addv(0, 0, 1, 20'hBC010, 8'h00, 1, 0, 8'h77, DA,       1, 0, 0, 1, 8'h3C, 8'hA5);
        addv(0, 0, 1, 20'hBC010, 8'h00, 0, 0, 8'h77, 19'h0C010, 1, 0, 1, 1, 8'h3C, 8'hA5);
        addv(0, 0, 1, 20'hBC010, 8'h00, 0, 0, 8'h77, DA,       1, 1, 0, 1, 8'h77, 8'hA5);
        for (int i = 0; i < 3; i++)
            addv(0, 1, 1, 20'h0, 8'h00, 0, 0, 8'h00, DA,       1, 1, 0, 0, 8'h77, 8'hA5);

        for (int i = 0; i < vq.size(); i++) begin
            reset = vq[i].rst; if_a.bus_memr_l = vq[i].memr_l; if_a.bus_memw_l = vq[i].memw_l;
            if_a.bus_a = vq[i].a; if_a.bus_d = vq[i].d; disp_read = vq[i].dr;
            isa_op_enable = vq[i].op; ram_d = vq[i].rd;
            tick();
            chk($sformatf("v%0d ram_a", i),    32'(ram_a_a),          32'(vq[i].e_ram_a));
            chk($sformatf("v%0d ram_we_l", i), 32'(we_a),             32'(vq[i].e_we_l));
            chk($sformatf("v%0d bus_rdy", i),  32'(if_a.bus_rdy),     32'(vq[i].e_rdy));
            chk($sformatf("v%0d cpu_acc", i),  32'(cpu_a),            32'(vq[i].e_cpu));
            chk($sformatf("v%0d mem_dir", i),  32'(if_a.bus_mem_dir), 32'(vq[i].e_dir));
            chk($sformatf("v%0d out_mem", i),  32'(if_a.bus_out_mem), 32'(vq[i].e_out));
            chk($sformatf("v%0d ram_dout", i), 32'(ram_dout_a),       32'(vq[i].e_dout));
        end

        // reset asserted while a write is on the RAM pins
        disp_read = 1'b0; isa_op_enable = 1'b0;
        if_a.bus_a = 20'hB8123; if_a.bus_d = 8'h99; if_a.bus_memw_l = 1'b0;
        repeat (3) begin
            tick();
            chk("rst_seq wait", 32'(if_a.bus_rdy), 32'd0);
        end
        isa_op_enable = 1'b1;
        tick();
        chk("rst_seq we_low", 32'(we_a), 32'd0);
        chk("rst_seq cpu", 32'(cpu_a), 32'd1);
        reset = 1'b1; if_a.bus_memw_l = 1'b1; isa_op_enable = 1'b0;
        tick();
        chk("rst_seq we_l", 32'(we_a), 32'd1);
        chk("rst_seq rdy", 32'(if_a.bus_rdy), 32'd1);
        chk("rst_seq out", 32'(if_a.bus_out_mem), 32'd0);
        chk("rst_seq dout", 32'(ram_dout_a), 32'd0);
        chk("rst_seq cpu0", 32'(cpu_a), 32'd0);
        chk("rst_seq ram_a", 32'(ram_a_a), 32'(DA));
        reset = 1'b0;
        repeat (4) begin
            tick();
            chk("rst_seq post we_l", 32'(we_a), 32'd1);
            chk("rst_seq post rdy", 32'(if_a.bus_rdy), 32'd1);
        end

        // no-wait variant: outside-window access, then an in-window read with RD_LAT=1
        if_b.bus_a = 20'hA0000; if_b.bus_memr_l = 1'b0; ram_d = 8'hE1;
        repeat (5) begin
            tick();
            chk("nw outside rdy", 32'(if_b.bus_rdy), 32'd1);
            chk("nw outside we_l", 32'(we_b), 32'd1);
            chk("nw outside cpu", 32'(cpu_b), 32'd0);
            chk("nw outside ram_a", 32'(ram_a_b), 32'(DA));
            chk("nw outside dir", 32'(if_b.bus_mem_dir), 32'd0);
        end
        if_b.bus_a = 20'hB8005; isa_op_enable = 1'b1;
        tick();
        chk("nw req rdy", 32'(if_b.bus_rdy), 32'd1);
        chk("nw req cpu", 32'(cpu_b), 32'd0);
        tick();
        chk("nw acc cpu", 32'(cpu_b), 32'd1);
        chk("nw acc ram_a", 32'(ram_a_b), 32'h08005);
        chk("nw acc rdy", 32'(if_b.bus_rdy), 32'd1);
        chk("nw acc out", 32'(if_b.bus_out_mem), 32'd0);
        tick();
        chk("nw done out", 32'(if_b.bus_out_mem), 32'hE1);
        chk("nw done cpu", 32'(cpu_b), 32'd0);
        chk("nw done rdy", 32'(if_b.bus_rdy), 32'd1);
        if_b.bus_memr_l = 1'b1; isa_op_enable = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
